// File: rtl/exception_seq_pkg.sv
// Shared CPU definitions for the exception sequencer: vector selects, cause codes and FSM states.
package exception_seq_pkg;

  localparam logic [2:0] SEL_VEC_OPC  = 3'b100;
  localparam logic [2:0] SEL_VEC_OVF  = 3'b101;
  localparam logic [2:0] SEL_VEC_DIV0 = 3'b110;

  typedef enum logic [1:0] {
    CauseNone = 2'b00,
    CauseOpc  = 2'b01,
    CauseOvf  = 2'b10,
    CauseDiv0 = 2'b11
  } cause_e;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StLoad,
    StDone
  } state_e;

  function automatic logic [2:0] vec_sel(cause_e cause);
    logic [2:0] sel;
    case (cause)
      CauseOvf:  sel = SEL_VEC_OVF;
      CauseDiv0: sel = SEL_VEC_DIV0;
      default:   sel = SEL_VEC_OPC;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/exception_seq.sv
// Exception sequencer: overrides the memory-address select with a vector code, writes EPC,
// waits out memory latency and loads PC with the handler byte while stalling the control unit.
module exception_seq
  import exception_seq_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ctrl_addr_sel,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] pc_current,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  addr_sel_out,
  output logic        epc_wr,
  output logic [31:0] epc_value,
  output logic        pc_wr,
  output logic [31:0] pc_value,
  output logic [1:0]  exc_cause,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] LatInit = 3'(MEM_LAT);

  state_e     state_q;
  cause_e     cause_q;
  logic [2:0] cnt_q;

  // Only the low byte of memory data forms the handler address.
  logic unused_mem_hi;
  assign unused_mem_hi = ^mem_data_in[31:8];

  assign exc_cause = cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cause_q   <= CauseNone;
      cnt_q     <= 3'd0;
      epc_value <= 32'd0;
      pc_value  <= 32'd0;
      epc_wr    <= 1'b0;
      pc_wr     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      epc_wr <= 1'b0;
      pc_wr  <= 1'b0;
      done   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (exc_opcode || exc_ovf || exc_div0) begin
            if (exc_opcode)   cause_q <= CauseOpc;
            else if (exc_ovf) cause_q <= CauseOvf;
            else              cause_q <= CauseDiv0;
            // PC arrives pre-incremented; EPC must point at the faulting instruction.
            epc_value <= pc_current - 32'd4;
            epc_wr    <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          cnt_q   <= LatInit;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            pc_value <= {24'h0, mem_data_in[7:0]};
            pc_wr    <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    addr_sel_out = ctrl_addr_sel;
    if (state_q == StAddr || state_q == StWait || state_q == StLoad) begin
      addr_sel_out = vec_sel(cause_q);
    end
  end

endmodule

// File: tb/tb_exception_seq.sv
// Bench for exception_seq: two instances (MEM_LAT 1 and 3) checked every cycle against a
// cycle-offset model, plus directed literal checks.
module tb_exception_seq;

  localparam int NDut = 2;
  localparam int Lat0 = 1;
  localparam int Lat1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ctrl_addr_sel;
  logic        exc_opcode, exc_ovf, exc_div0;
  logic [31:0] pc_current, mem_data_in;

  logic [2:0]  addr_sel_out [NDut];
  logic        epc_wr       [NDut];
  logic [31:0] epc_value    [NDut];
  logic        pc_wr        [NDut];
  logic [31:0] pc_value     [NDut];
  logic [1:0]  exc_cause    [NDut];
  logic        busy         [NDut];
  logic        done         [NDut];

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  exception_seq #(.MEM_LAT(Lat0)) u_dut0 (
    .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl_addr_sel),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .pc_current(pc_current), .mem_data_in(mem_data_in),
    .addr_sel_out(addr_sel_out[0]), .epc_wr(epc_wr[0]), .epc_value(epc_value[0]),
    .pc_wr(pc_wr[0]), .pc_value(pc_value[0]), .exc_cause(exc_cause[0]),
    .busy(busy[0]), .done(done[0])
  );

  exception_seq #(.MEM_LAT(Lat1)) u_dut1 (
    .clk(clk), .reset(reset), .ctrl_addr_sel(ctrl_addr_sel),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .pc_current(pc_current), .mem_data_in(mem_data_in),
    .addr_sel_out(addr_sel_out[1]), .epc_wr(epc_wr[1]), .epc_value(epc_value[1]),
    .pc_wr(pc_wr[1]), .pc_value(pc_value[1]), .exc_cause(exc_cause[1]),
    .busy(busy[1]), .done(done[1])
  );

  // Model: m_d is the number of cycles since the sampling edge (0 = idle).
  int          m_d     [NDut];
  int          m_lat   [NDut];
  int          m_cause [NDut];
  logic [31:0] m_epc   [NDut];
  logic [31:0] m_pc    [NDut];

  initial begin
    m_lat[0] = Lat0;
    m_lat[1] = Lat1;
    for (int i = 0; i < NDut; i++) begin
      m_d[i] = 0; m_cause[i] = 0; m_epc[i] = 0; m_pc[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NDut; i++) begin
      if (reset) begin
        m_d[i] = 0; m_cause[i] = 0; m_epc[i] = 0; m_pc[i] = 0;
      end else begin
        if (m_d[i] == 1 + m_lat[i]) m_pc[i] = {24'h0, mem_data_in[7:0]};
        if (m_d[i] > 0) begin
          m_d[i] = (m_d[i] == 3 + m_lat[i]) ? 0 : m_d[i] + 1;
        end else if (exc_opcode || exc_ovf || exc_div0) begin
          m_cause[i] = exc_opcode ? 1 : (exc_ovf ? 2 : 3);
          m_epc[i]   = pc_current - 32'd4;
          m_d[i]     = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < NDut; i++) begin
        int d;
        int l;
        logic [2:0] exp_sel;
        d = m_d[i];
        l = m_lat[i];
        exp_sel = (d >= 1 && d <= 2 + l) ? 3'(3 + m_cause[i]) : ctrl_addr_sel;
        chk($sformatf("cyc%0d addr_sel", i), 32'(addr_sel_out[i]), 32'(exp_sel));
        chk($sformatf("cyc%0d epc_wr", i), 32'(epc_wr[i]), 32'(d == 1));
        chk($sformatf("cyc%0d pc_wr", i), 32'(pc_wr[i]), 32'(d == 2 + l));
        chk($sformatf("cyc%0d done", i), 32'(done[i]), 32'(d == 3 + l));
        chk($sformatf("cyc%0d busy", i), 32'(busy[i]), 32'(d >= 1));
        chk($sformatf("cyc%0d epc_value", i), epc_value[i], m_epc[i]);
        chk($sformatf("cyc%0d pc_value", i), pc_value[i], m_pc[i]);
        chk($sformatf("cyc%0d exc_cause", i), 32'(exc_cause[i]), 32'(m_cause[i]));
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    int n_pcwr;
    reset = 1'b1; ctrl_addr_sel = 3'b000;
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
    pc_current = 32'd0; mem_data_in = 32'd0;
    idle_cycles(2);
    chk_en = 1;
    reset = 1'b0; ctrl_addr_sel = 3'b011;
    @(negedge clk);
    chk("reset_passthru", 32'(addr_sel_out[0]), 32'h3);
    chk("reset_busy", 32'(busy[0]), 32'h0);
    chk("reset_cause", 32'(exc_cause[0]), 32'h0);

    // Overflow, observed on the MEM_LAT=1 instance.
    pc_current = 32'h0000_0040; mem_data_in = 32'h0000_00A8; exc_ovf = 1'b1;
    @(negedge clk);  // E+1
    exc_ovf = 1'b0;
    chk("ovf_addr_e1", 32'(addr_sel_out[0]), 32'h5);
    chk("ovf_epc_wr", 32'(epc_wr[0]), 32'h1);
    chk("ovf_epc_value", epc_value[0], 32'h0000_003C);
    @(negedge clk);  // E+2
    chk("ovf_addr_e2", 32'(addr_sel_out[0]), 32'h5);
    @(negedge clk);  // E+3
    chk("ovf_addr_e3", 32'(addr_sel_out[0]), 32'h5);
    chk("ovf_pc_wr", 32'(pc_wr[0]), 32'h1);
    chk("ovf_pc_value", pc_value[0], 32'h0000_00A8);
    @(negedge clk);  // E+4
    chk("ovf_done", 32'(done[0]), 32'h1);
    chk("ovf_done_sel", 32'(addr_sel_out[0]), 32'h3);
    chk("ovf_cause", 32'(exc_cause[0]), 32'h2);
    idle_cycles(6);

    // Coincident opcode and div0: opcode wins.
    ctrl_addr_sel = 3'b001; pc_current = 32'h0000_1000;
    exc_opcode = 1'b1; exc_div0 = 1'b1;
    @(negedge clk);
    exc_opcode = 1'b0; exc_div0 = 1'b0;
    chk("prio_addr", 32'(addr_sel_out[0]), 32'h4);
    chk("prio_cause", 32'(exc_cause[0]), 32'h1);
    idle_cycles(8);
    chk("cause_held", 32'(exc_cause[1]), 32'h1);

    // div0 raised during WAIT must be dropped.
    mem_data_in = 32'h0000_0033; exc_ovf = 1'b1;
    n_pcwr = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exc_ovf  = 1'b0;
      exc_div0 = (k == 2 || k == 3);
      n_pcwr += int'(pc_wr[1]);
    end
    chk("busy_filter_pcwr", 32'(n_pcwr), 32'd1);
    chk("busy_filter_cause", 32'(exc_cause[1]), 32'h2);

    // Reset while both instances sit in WAIT.
    pc_current = 32'h0000_2000; mem_data_in = 32'h0000_0077; exc_ovf = 1'b1;
    @(negedge clk);  // E+1
    exc_ovf = 1'b0;
    @(negedge clk);  // E+2
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy[1]), 32'h0);
    chk("rst_mid_epc", epc_value[1], 32'h0);
    chk("rst_mid_pc", pc_value[0], 32'h0);
    chk("rst_mid_cause", 32'(exc_cause[1]), 32'h0);
    chk("rst_mid_sel", 32'(addr_sel_out[1]), 32'h1);
    n_pcwr = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_pcwr += int'(pc_wr[0]) + int'(pc_wr[1]);
    end
    chk("rst_mid_no_pcwr", 32'(n_pcwr), 32'd0);

    // Wrap-around EPC and wide memory data on the MEM_LAT=3 instance.
    pc_current = 32'd0; mem_data_in = 32'hFFFF_FF10; exc_div0 = 1'b1;
    @(negedge clk);  // E+1
    exc_div0 = 1'b0;
    chk("wrap_epc", epc_value[1], 32'hFFFF_FFFC);
    chk("wrap_sel", 32'(addr_sel_out[1]), 32'h6);
    idle_cycles(4);  // E+5
    chk("wrap_pc_wr", 32'(pc_wr[1]), 32'h1);
    chk("wrap_pc_value", pc_value[1], 32'h0000_0010);
    @(negedge clk);  // E+6
    chk("wrap_done", 32'(done[1]), 32'h1);
    @(negedge clk);  // E+7
    chk("wrap_idle", 32'(busy[1]), 32'h0);
    idle_cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
